display_value_select: RTL and testbench

//   Parametrised successor of the seven-segment value selector. Picks one of NUM_SRC

---
 rtl/display_value_select_if.sv | 34 +++
 rtl/display_value_select.sv | 173 +++++++++++++++++
 tb/tb_display_value_select.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/display_value_select_if.sv
// Bundle of selection controls, packed source data and display outputs for
// display_value_select; the master drives the controls, the slave drives the display.
interface display_value_select_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 2,
  parameter int DIGITS  = 4
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [SW-1:0]            src_sel;
  logic [NUM_SRC-1:0]       src_valid;
  logic [2:0]               data_type_sel;
  logic                     bcd_on;
  logic                     hold;
  logic [NUM_SRC*WIDTH-1:0] raw_data;
  logic [NUM_SRC*WIDTH-1:0] avg_data;
  logic [NUM_SRC*WIDTH-1:0] scaled_data;
  logic [4*DIGITS-1:0]      mux_out;
  logic [DIGITS-1:0]        decimal_point;
  logic                     overflow;
  logic                     update_strobe;

  modport master (
    output src_sel, src_valid, data_type_sel, bcd_on, hold,
           raw_data, avg_data, scaled_data,
    input  mux_out, decimal_point, overflow, update_strobe
  );

  modport slave (
    input  src_sel, src_valid, data_type_sel, bcd_on, hold,
           raw_data, avg_data, scaled_data,
    output mux_out, decimal_point, overflow, update_strobe
  );
endinterface

// File: rtl/display_value_select.sv
// Seven-segment value selector: picks a source/data type, samples it at the refresh
// rate and drives registered hex or BCD digits with decimal point, overflow and strobe.
module display_value_select #(
  parameter int WIDTH      = 16,
  parameter int NUM_SRC    = 2,
  parameter int DIGITS     = 4,
  parameter int UPDATE_DIV = 100000,
  parameter int DP_POS     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  display_value_select_if.slave bus
);
  localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int BW  = 4 * DIGITS;
  localparam int STW = $clog2(WIDTH + 1);

  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] bcd);
    logic [BW-1:0] r;
    r = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = bcd[4*d +: 4];
      end
    end
    return r;
  endfunction

  localparam logic [63:0]       MAX_DEC = max_dec(DIGITS);
  localparam logic [BW-1:0]     NINES   = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] DP_MASK = DIGITS'(1) << DP_POS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     count_r;
  logic              tick_s;
  logic [WIDTH-1:0]  sel_value_s;
  logic [WIDTH-1:0]  bin_r;
  logic [BW-1:0]     bcd_r;
  logic [BW-1:0]     bcd_adj_s;
  logic [STW-1:0]    steps_r;
  logic              hex_mode_r;
  logic              ovf_r;
  logic              dp_r;
  logic [BW-1:0]     mux_out_r;
  logic [DIGITS-1:0] decimal_point_r;
  logic              overflow_r;
  logic              update_strobe_r;

  // Source/type selection; unmatched index, disabled source or non-one-hot type reads 0.
  always_comb begin
    logic             hit_v;
    logic [WIDTH-1:0] field_v;
    sel_value_s = '0;
    hit_v       = 1'b0;
    field_v     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_v = (bus.src_sel == SW'(i)) && bus.src_valid[i];
      case (bus.data_type_sel)
        3'b001:  field_v = bus.raw_data[i*WIDTH +: WIDTH];
        3'b010:  field_v = bus.avg_data[i*WIDTH +: WIDTH];
        3'b100:  field_v = bus.scaled_data[i*WIDTH +: WIDTH];
        default: field_v = '0;
      endcase
      sel_value_s = sel_value_s | (hit_v ? field_v : {WIDTH{1'b0}});
    end
  end

  assign tick_s    = (count_r == CW'(UPDATE_DIV - 1));
  assign bcd_adj_s = add3(bcd_r);

  // Free-running refresh divider, independent of the FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (tick_s) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  // Sample / convert / load sequencer with registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      bin_r           <= '0;
      bcd_r           <= '0;
      steps_r         <= '0;
      hex_mode_r      <= 1'b0;
      ovf_r           <= 1'b0;
      dp_r            <= 1'b0;
      mux_out_r       <= '0;
      decimal_point_r <= '0;
      overflow_r      <= 1'b0;
      update_strobe_r <= 1'b0;
    end else begin
      update_strobe_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (tick_s && !bus.hold) begin
            bin_r      <= sel_value_s;
            bcd_r      <= '0;
            steps_r    <= STW'(WIDTH);
            hex_mode_r <= !bus.bcd_on;
            dp_r       <= bus.bcd_on && (bus.data_type_sel == 3'b100);
            if (!bus.bcd_on) begin
              ovf_r   <= 1'b0;
              state_r <= ST_LOAD;
            end else if (64'(sel_value_s) > MAX_DEC) begin
              ovf_r   <= 1'b1;
              state_r <= ST_LOAD;
            end else begin
              ovf_r   <= 1'b0;
              state_r <= ST_CONVERT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CONVERT: begin
          bcd_r   <= {bcd_adj_s[BW-2:0], bin_r[WIDTH-1]};
          bin_r   <= bin_r << 1;
          steps_r <= steps_r - STW'(1);
          if (steps_r == STW'(1)) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_CONVERT;
          end
        end
        ST_LOAD: begin
          if (ovf_r) begin
            mux_out_r <= NINES;
          end else if (hex_mode_r) begin
            mux_out_r <= BW'(bin_r);
          end else begin
            mux_out_r <= bcd_r;
          end
          overflow_r      <= ovf_r;
          decimal_point_r <= dp_r ? DP_MASK : {DIGITS{1'b0}};
          update_strobe_r <= 1'b1;
          state_r         <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mux_out       = mux_out_r;
  assign bus.decimal_point = decimal_point_r;
  assign bus.overflow      = overflow_r;
  assign bus.update_strobe = update_strobe_r;
endmodule

// File: tb/tb_display_value_select.sv
// Directed bench for display_value_select with UPDATE_DIV=4: hex/BCD latency,
// overflow, zero selection, hold and asynchronous reset during conversion.
module tb_display_value_select;
  localparam int WIDTH   = 16;
  localparam int NUM_SRC = 2;
  localparam int DIGITS  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [1:0] tb_cnt;

  always #5 clk = ~clk;

  display_value_select_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DIGITS(DIGITS)) bus ();

  display_value_select #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DIGITS(DIGITS), .UPDATE_DIV(4), .DP_POS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Bench model of the refresh divider: tick on the edge where the count is 3.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cnt <= 2'd0;
    else        tb_cnt <= tb_cnt + 2'd1;
  end

  task automatic wait_tick();
    int guard;
    guard = 0;
    @(negedge clk);
    while (tb_cnt != 2'd3 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (tb_cnt != 2'd3) begin
      total++; bad++;
      $display("FAIL tick_wait: count=%0d required=3", tb_cnt);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    bus.src_sel = 1'b0; bus.src_valid = 2'b00; bus.data_type_sel = 3'b001;
    bus.bcd_on = 1'b0; bus.hold = 1'b0;
    bus.raw_data = '0; bus.avg_data = '0; bus.scaled_data = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h0000) begin bad++; $display("FAIL reset_mux: got %h want 0000", bus.mux_out); end
    total++; if (bus.decimal_point !== 4'b0000) begin bad++; $display("FAIL reset_dp: got %b want 0000", bus.decimal_point); end
    total++; if (bus.overflow !== 1'b0 || bus.update_strobe !== 1'b0) begin bad++; $display("FAIL reset_flags: ovf=%b strobe=%b want 0 0", bus.overflow, bus.update_strobe); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.update_strobe !== 1'b0) begin bad++; $display("FAIL reset_idle: mux=%h strobe=%b want 0000 0", bus.mux_out, bus.update_strobe); end
  endtask

  task automatic test_hex();
    int pulses;
    bus.src_valid = 2'b10; bus.src_sel = 1'b1; bus.raw_data[WIDTH +: WIDTH] = 16'h00AB;
    bus.data_type_sel = 3'b001; bus.bcd_on = 1'b0;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h00AB) begin bad++; $display("FAIL hex_mux: got %h want 00ab", bus.mux_out); end
    total++; if (bus.decimal_point !== 4'b0000) begin bad++; $display("FAIL hex_dp: got %b want 0000", bus.decimal_point); end
    pulses = (bus.update_strobe === 1'b1) ? 1 : 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.update_strobe === 1'b1) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL hex_strobe: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_bcd_scaled();
    bus.src_sel = 1'b0; bus.src_valid = 2'b11; bus.scaled_data[0 +: WIDTH] = 16'd3300;
    bus.data_type_sel = 3'b100; bus.bcd_on = 1'b1;
    wait_tick();
    repeat (16) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h00AB || bus.update_strobe !== 1'b0) begin bad++; $display("FAIL bcd_early: mux=%h strobe=%b want 00ab 0", bus.mux_out, bus.update_strobe); end
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h3300) begin bad++; $display("FAIL bcd_mux: got %h want 3300", bus.mux_out); end
    total++; if (bus.decimal_point !== 4'b1000) begin bad++; $display("FAIL bcd_dp: got %b want 1000", bus.decimal_point); end
    total++; if (bus.overflow !== 1'b0 || bus.update_strobe !== 1'b1) begin bad++; $display("FAIL bcd_flags: ovf=%b strobe=%b want 0 1", bus.overflow, bus.update_strobe); end
  endtask

  task automatic test_overflow();
    bus.src_sel = 1'b0; bus.data_type_sel = 3'b010; bus.bcd_on = 1'b1;
    bus.avg_data[0 +: WIDTH] = 16'd12345;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h9999 || bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_big: mux=%h ovf=%b want 9999 1", bus.mux_out, bus.overflow); end
    total++; if (bus.decimal_point !== 4'b0000) begin bad++; $display("FAIL ovf_dp: got %b want 0000", bus.decimal_point); end
    bus.avg_data[0 +: WIDTH] = 16'd9999;
    wait_tick();
    repeat (16) @(posedge clk);
    #1;
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_hold: got %b want 1", bus.overflow); end
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h9999 || bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_9999: mux=%h ovf=%b want 9999 0", bus.mux_out, bus.overflow); end
    bus.avg_data[0 +: WIDTH] = 16'd0;
    wait_tick();
    repeat (17) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_zero: mux=%h ovf=%b want 0000 0", bus.mux_out, bus.overflow); end
  endtask

  task automatic test_zero_select();
    bus.src_valid = 2'b11; bus.src_sel = 1'b1; bus.raw_data[WIDTH +: WIDTH] = 16'h1234;
    bus.data_type_sel = 3'b001; bus.bcd_on = 1'b0;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h1234) begin bad++; $display("FAIL sel_hex: got %h want 1234", bus.mux_out); end
    bus.src_valid = 2'b01;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.decimal_point !== 4'b0000) begin bad++; $display("FAIL sel_invalid: mux=%h dp=%b want 0000 0000", bus.mux_out, bus.decimal_point); end
    bus.src_valid = 2'b11; bus.scaled_data[WIDTH +: WIDTH] = 16'd3300;
    bus.data_type_sel = 3'b100; bus.bcd_on = 1'b1;
    wait_tick();
    repeat (17) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h3300 || bus.decimal_point !== 4'b1000) begin bad++; $display("FAIL sel_src1: mux=%h dp=%b want 3300 1000", bus.mux_out, bus.decimal_point); end
    bus.data_type_sel = 3'b011;
    wait_tick();
    repeat (17) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.decimal_point !== 4'b0000) begin bad++; $display("FAIL sel_type: mux=%h dp=%b want 0000 0000", bus.mux_out, bus.decimal_point); end
  endtask

  task automatic test_hold();
    int strobes;
    int changed;
    bus.src_valid = 2'b11; bus.src_sel = 1'b1; bus.raw_data[WIDTH +: WIDTH] = 16'h0042;
    bus.data_type_sel = 3'b001; bus.bcd_on = 1'b0;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h0042) begin bad++; $display("FAIL hold_pre: got %h want 0042", bus.mux_out); end
    bus.hold = 1'b1; bus.raw_data[WIDTH +: WIDTH] = 16'h00FF;
    strobes = 0; changed = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.update_strobe !== 1'b0) strobes++;
      if (bus.mux_out !== 16'h0042) changed++;
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL hold_strobe: got %0d want 0", strobes); end
    total++; if (changed != 0) begin bad++; $display("FAIL hold_frozen: got %0d changes want 0", changed); end
    bus.hold = 1'b0;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h00FF || bus.update_strobe !== 1'b1) begin bad++; $display("FAIL hold_release: mux=%h strobe=%b want 00ff 1", bus.mux_out, bus.update_strobe); end
  endtask

  task automatic test_reset_mid();
    bus.src_sel = 1'b0; bus.src_valid = 2'b11; bus.scaled_data[0 +: WIDTH] = 16'd12345;
    bus.data_type_sel = 3'b100; bus.bcd_on = 1'b1;
    wait_tick();
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h9999 || bus.overflow !== 1'b1 || bus.decimal_point !== 4'b1000) begin bad++; $display("FAIL mid_pre: mux=%h ovf=%b dp=%b want 9999 1 1000", bus.mux_out, bus.overflow, bus.decimal_point); end
    bus.scaled_data[0 +: WIDTH] = 16'd1234;
    wait_tick();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.decimal_point !== 4'b0000 || bus.overflow !== 1'b0 || bus.update_strobe !== 1'b0) begin bad++; $display("FAIL mid_async: mux=%h dp=%b ovf=%b strobe=%b want all 0", bus.mux_out, bus.decimal_point, bus.overflow, bus.update_strobe); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    repeat (16) @(posedge clk);
    #1;
    total++; if (bus.mux_out !== 16'h0000 || bus.update_strobe !== 1'b0) begin bad++; $display("FAIL mid_early: mux=%h strobe=%b want 0000 0", bus.mux_out, bus.update_strobe); end
    @(posedge clk); #1;
    total++; if (bus.mux_out !== 16'h1234 || bus.decimal_point !== 4'b1000 || bus.update_strobe !== 1'b1) begin bad++; $display("FAIL mid_first: mux=%h dp=%b strobe=%b want 1234 1000 1", bus.mux_out, bus.decimal_point, bus.update_strobe); end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_bcd_scaled();
    test_overflow();
    test_zero_select();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
